// File: rtl/ddr2_pkg.sv
// ----------------------------------------------------------------------------
// ddr2_pkg
// Shared definitions for the DDR2 command-bus arbiter:
//   - DDR2 command encodings {cs,ras,cas,we}
//   - arbiter FSM state enum
//   - bit positions of the one-hot pick/grant vector
// No ports (package).
// ----------------------------------------------------------------------------
package ddr2_pkg;

   localparam logic [3:0] CMD_LM   = 4'b0000;
   localparam logic [3:0] CMD_AREF = 4'b0001;
   localparam logic [3:0] CMD_PRE  = 4'b0010;
   localparam logic [3:0] CMD_ACT  = 4'b0011;
   localparam logic [3:0] CMD_WR   = 4'b0100;
   localparam logic [3:0] CMD_RD   = 4'b0101;
   localparam logic [3:0] CMD_NOP  = 4'b0111;

   typedef enum logic [2:0] {
      ST_INIT  = 3'd0,
      ST_ARB   = 3'd1,
      ST_AREF  = 3'd2,
      ST_WRITE = 3'd3,
      ST_READ  = 3'd4
   } state_t;

   // Bit positions inside the 3-bit one-hot pick / grant vector.
   localparam int PICK_RD   = 0;
   localparam int PICK_WR   = 1;
   localparam int PICK_AREF = 2;

endpackage

// File: rtl/ddr2_arb_pick.sv
// ----------------------------------------------------------------------------
// ddr2_arb_pick
// Combinational chooser for the next bus owner.
// Refresh has fixed top priority; write and read alternate when both request.
// Ports:
//   aref_req, wr_req, rd_req  in   level requests
//   last_served               in   ST_WRITE or ST_READ: last data source served
//   pick                      out  one-hot {aref, wr, rd} (bit positions PICK_*),
//                                  all zero when nobody requests
// ----------------------------------------------------------------------------
module ddr2_arb_pick
   import ddr2_pkg::*;
(
   input  logic       aref_req,
   input  logic       wr_req,
   input  logic       rd_req,
   input  state_t     last_served,
   output logic [2:0] pick
);

   always_comb begin
      pick = 3'b000;
      if (aref_req) begin
         pick[PICK_AREF] = 1'b1;
      end else if (wr_req && rd_req) begin
         // Both data sources waiting: the one not served last goes next.
         if (last_served == ST_WRITE) begin
            pick[PICK_RD] = 1'b1;
         end else begin
            pick[PICK_WR] = 1'b1;
         end
      end else if (wr_req) begin
         pick[PICK_WR] = 1'b1;
      end else if (rd_req) begin
         pick[PICK_RD] = 1'b1;
      end
   end

endmodule

// File: rtl/ddr2_cmd_arbiter.sv
// ----------------------------------------------------------------------------
// ddr2_cmd_arbiter
// Owns the DDR2 command/address bus. Until init_end is seen the init
// sequencer's cke/cmd/ba/addr are passed through (one cycle of latency).
// Afterwards the bus is granted to auto-refresh (highest priority) or to the
// write/read sources (round-robin). Every grant is separated by at least one
// ARB cycle, which drives NOP onto the bus.
//
// Optional feature macro: DDR2_ARB_TIMEOUT_EN
//   defined   : a grant held for MAX_GRANT_CYCLES cycles without *_done is
//               revoked, NOP is driven and grant_timeout pulses for one cycle
//   undefined : grants last until *_done; grant_timeout is tied to 0
//
// Handshake: *_req is a level held by the source; *_gnt is registered and is
// high on every cycle the source owns the bus, starting with the entry
// cycle; the owner releases with a one-cycle *_done pulse (entry cycle
// included), after which *_gnt falls on the same edge the FSM returns to ARB.
// *_done from a source that does not own the bus is ignored.
//
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   init_end, init_cke/cmd/ba/addr init sequencer interface
//   {aref,wr,rd}_req/_done         source request level / release pulse
//   {aref,wr,rd}_gnt               registered grants
//   {aref,wr,rd}_cmd/_ba/_addr     source command buses
//   ddr2_cke/cmd/ba/addr           registered bus toward the PHY
//   grant_timeout                  one-cycle timeout error pulse
//   dbg_state                      current FSM state (observability)
// ----------------------------------------------------------------------------
module ddr2_cmd_arbiter
   import ddr2_pkg::*;
#(
   parameter int BA_BITS          = 3,
   parameter int ADDR_BITS        = 13,
   parameter int MAX_GRANT_CYCLES = 64
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 init_end,
   input  logic                 init_cke,
   input  logic [3:0]           init_cmd,
   input  logic [BA_BITS-1:0]   init_ba,
   input  logic [ADDR_BITS-1:0] init_addr,
   input  logic                 aref_req,
   input  logic                 wr_req,
   input  logic                 rd_req,
   input  logic                 aref_done,
   input  logic                 wr_done,
   input  logic                 rd_done,
   output logic                 aref_gnt,
   output logic                 wr_gnt,
   output logic                 rd_gnt,
   input  logic [3:0]           aref_cmd,
   input  logic [3:0]           wr_cmd,
   input  logic [3:0]           rd_cmd,
   input  logic [BA_BITS-1:0]   aref_ba,
   input  logic [BA_BITS-1:0]   wr_ba,
   input  logic [BA_BITS-1:0]   rd_ba,
   input  logic [ADDR_BITS-1:0] aref_addr,
   input  logic [ADDR_BITS-1:0] wr_addr,
   input  logic [ADDR_BITS-1:0] rd_addr,
   output logic                 ddr2_cke,
   output logic [3:0]           ddr2_cmd,
   output logic [BA_BITS-1:0]   ddr2_ba,
   output logic [ADDR_BITS-1:0] ddr2_addr,
   output logic                 grant_timeout,
   output state_t               dbg_state
);

   state_t                 state_q;
   state_t                 last_served_q;
   logic [2:0]             gnt_q;
   logic                   ddr2_cke_q;
   logic [3:0]             ddr2_cmd_q;
   logic [BA_BITS-1:0]     ddr2_ba_q;
   logic [ADDR_BITS-1:0]   ddr2_addr_q;

   logic [2:0]             pick;
   logic [3:0]             sel_cmd;
   logic [BA_BITS-1:0]     sel_ba;
   logic [ADDR_BITS-1:0]   sel_addr;
   logic                   sel_done;
   logic                   timeout_fire;

   ddr2_arb_pick u_pick (
      .aref_req    (aref_req),
      .wr_req      (wr_req),
      .rd_req      (rd_req),
      .last_served (last_served_q),
      .pick        (pick)
   );

   // Route the current owner's bus and release pulse; the other sources'
   // done pulses never reach the FSM.
   always_comb begin
      sel_cmd  = CMD_NOP;
      sel_ba   = '0;
      sel_addr = '0;
      sel_done = 1'b0;
      case (state_q)
         ST_AREF: begin
            sel_cmd  = aref_cmd;
            sel_ba   = aref_ba;
            sel_addr = aref_addr;
            sel_done = aref_done;
         end
         ST_WRITE: begin
            sel_cmd  = wr_cmd;
            sel_ba   = wr_ba;
            sel_addr = wr_addr;
            sel_done = wr_done;
         end
         ST_READ: begin
            sel_cmd  = rd_cmd;
            sel_ba   = rd_ba;
            sel_addr = rd_addr;
            sel_done = rd_done;
         end
         default: ;
      endcase
   end

`ifdef DDR2_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(MAX_GRANT_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q;
   logic             timeout_q;

   // cnt_q counts completed grant cycles; the last allowed cycle is
   // MAX_GRANT_CYCLES-1, so the grant is high exactly MAX_GRANT_CYCLES cycles.
   always_comb begin
      timeout_fire = 1'b0;
      if ((state_q == ST_AREF) || (state_q == ST_WRITE) || (state_q == ST_READ)) begin
         timeout_fire = !sel_done && (cnt_q == CNT_W'(MAX_GRANT_CYCLES - 1));
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= timeout_fire;
         if ((state_q == ST_AREF) || (state_q == ST_WRITE) || (state_q == ST_READ)) begin
            cnt_q <= cnt_q + 1'b1;
         end else begin
            cnt_q <= '0;
         end
      end
   end

   assign grant_timeout = timeout_q;
`else
   assign timeout_fire  = 1'b0;
   assign grant_timeout = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= ST_INIT;
         last_served_q <= ST_READ;
         gnt_q         <= 3'b000;
         ddr2_cke_q    <= 1'b0;
         ddr2_cmd_q    <= CMD_NOP;
         ddr2_ba_q     <= '0;
         ddr2_addr_q   <= '0;
      end else begin
         case (state_q)
            ST_INIT: begin
               ddr2_cke_q  <= init_cke;
               ddr2_cmd_q  <= init_cmd;
               ddr2_ba_q   <= init_ba;
               ddr2_addr_q <= init_addr;
               // Only reset brings the FSM back here, which makes init_end sticky.
               if (init_end) begin
                  state_q <= ST_ARB;
               end
            end

            ST_ARB: begin
               ddr2_cke_q <= 1'b1;
               ddr2_cmd_q <= CMD_NOP;
               gnt_q      <= pick;
               if (pick[PICK_AREF]) begin
                  state_q <= ST_AREF;
               end else if (pick[PICK_WR]) begin
                  state_q <= ST_WRITE;
               end else if (pick[PICK_RD]) begin
                  state_q <= ST_READ;
               end
            end

            ST_AREF, ST_WRITE, ST_READ: begin
               ddr2_cke_q  <= 1'b1;
               ddr2_cmd_q  <= timeout_fire ? CMD_NOP : sel_cmd;
               ddr2_ba_q   <= sel_ba;
               ddr2_addr_q <= sel_addr;
               if (sel_done || timeout_fire) begin
                  state_q <= ST_ARB;
                  gnt_q   <= 3'b000;
                  // Refresh does not take part in the write/read alternation.
                  if (state_q != ST_AREF) begin
                     last_served_q <= state_q;
                  end
               end
            end

            default: begin
               state_q <= ST_ARB;
               gnt_q   <= 3'b000;
            end
         endcase
      end
   end

   assign aref_gnt  = gnt_q[PICK_AREF];
   assign wr_gnt    = gnt_q[PICK_WR];
   assign rd_gnt    = gnt_q[PICK_RD];
   assign ddr2_cke  = ddr2_cke_q;
   assign ddr2_cmd  = ddr2_cmd_q;
   assign ddr2_ba   = ddr2_ba_q;
   assign ddr2_addr = ddr2_addr_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_ddr2_cmd_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ddr2_cmd_arbiter
// Directed bench for ddr2_cmd_arbiter. Inputs change on the falling edge and
// outputs are sampled on the falling edge, so each observation reflects the
// rising edge in between. Grant order is tracked with an expected queue.
// With DDR2_ARB_TIMEOUT_EN defined the DUT is built with MAX_GRANT_CYCLES = 8
// and the timeout path is exercised; otherwise an indefinite hold is checked.
// ----------------------------------------------------------------------------
module tb_ddr2_cmd_arbiter;
   import ddr2_pkg::*;

   localparam int BA_BITS   = 3;
   localparam int ADDR_BITS = 13;
`ifdef DDR2_ARB_TIMEOUT_EN
   localparam int MAXG = 8;
`else
   localparam int MAXG = 64;
`endif

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic                 init_end, init_cke;
   logic [3:0]           init_cmd;
   logic [BA_BITS-1:0]   init_ba;
   logic [ADDR_BITS-1:0] init_addr;
   logic                 aref_req, wr_req, rd_req;
   logic                 aref_done, wr_done, rd_done;
   logic                 aref_gnt, wr_gnt, rd_gnt;
   logic [3:0]           aref_cmd, wr_cmd, rd_cmd;
   logic [BA_BITS-1:0]   aref_ba, wr_ba, rd_ba;
   logic [ADDR_BITS-1:0] aref_addr, wr_addr, rd_addr;
   logic                 ddr2_cke;
   logic [3:0]           ddr2_cmd;
   logic [BA_BITS-1:0]   ddr2_ba;
   logic [ADDR_BITS-1:0] ddr2_addr;
   logic                 grant_timeout;
   state_t               dbg_state;

   ddr2_cmd_arbiter #(
      .BA_BITS          (BA_BITS),
      .ADDR_BITS        (ADDR_BITS),
      .MAX_GRANT_CYCLES (MAXG)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .init_end      (init_end),
      .init_cke      (init_cke),
      .init_cmd      (init_cmd),
      .init_ba       (init_ba),
      .init_addr     (init_addr),
      .aref_req      (aref_req),
      .wr_req        (wr_req),
      .rd_req        (rd_req),
      .aref_done     (aref_done),
      .wr_done       (wr_done),
      .rd_done       (rd_done),
      .aref_gnt      (aref_gnt),
      .wr_gnt        (wr_gnt),
      .rd_gnt        (rd_gnt),
      .aref_cmd      (aref_cmd),
      .wr_cmd        (wr_cmd),
      .rd_cmd        (rd_cmd),
      .aref_ba       (aref_ba),
      .wr_ba         (wr_ba),
      .rd_ba         (rd_ba),
      .aref_addr     (aref_addr),
      .wr_addr       (wr_addr),
      .rd_addr       (rd_addr),
      .ddr2_cke      (ddr2_cke),
      .ddr2_cmd      (ddr2_cmd),
      .ddr2_ba       (ddr2_ba),
      .ddr2_addr     (ddr2_addr),
      .grant_timeout (grant_timeout),
      .dbg_state     (dbg_state)
   );

   // ---------------- scoreboard state ----------------
   int         pass_cnt  = 0;
   int         total_cnt = 0;
   logic [1:0] exp_q[$];   // expected grant order: 1=AREF 2=WRITE 3=READ

   function automatic logic [1:0] gnt_id();
      if (aref_gnt) return 2'd1;
      if (wr_gnt)   return 2'd2;
      if (rd_gnt)   return 2'd3;
      return 2'd0;
   endfunction

   // Wait (bounded) for any grant; id stays 0 if none appears.
   task automatic wait_grant(output logic [1:0] id);
      id = 2'd0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (aref_gnt || wr_gnt || rd_gnt) begin
            id = gnt_id();
            break;
         end
      end
   endtask

   // ---------------- driver / scenario tasks ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      init_end = 1'b0; init_cke = 1'b1; init_cmd = CMD_PRE;
      init_ba = 3'd7; init_addr = 13'h1fff;
      {aref_req, wr_req, rd_req}    = 3'b000;
      {aref_done, wr_done, rd_done} = 3'b000;
      aref_cmd = CMD_AREF; wr_cmd = CMD_WR; rd_cmd = CMD_RD;
      aref_ba = 3'd0; wr_ba = 3'd1; rd_ba = 3'd2;
      aref_addr = 13'h0000; wr_addr = 13'h0123; rd_addr = 13'h0010;
      repeat (2) @(negedge clk);
      total_cnt++;
      if ({ddr2_cke, ddr2_cmd, ddr2_ba, ddr2_addr} !== {1'b0, CMD_NOP, 3'd0, 13'h0000})
         $display("FAIL reset_bus: got cke=%b cmd=%b ba=%h addr=%h, want cke=0 cmd=0111 ba=0 addr=0000",
                  ddr2_cke, ddr2_cmd, ddr2_ba, ddr2_addr);
      else pass_cnt++;
      total_cnt++;
      if ({aref_gnt, wr_gnt, rd_gnt, grant_timeout} !== 4'b0000)
         $display("FAIL reset_gnt: got gnt=%b%b%b to=%b, want 0000", aref_gnt, wr_gnt, rd_gnt, grant_timeout);
      else pass_cnt++;
      total_cnt++;
      if (dbg_state !== ST_INIT)
         $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_INIT);
      else pass_cnt++;
      rst_n = 1'b1;
   endtask

   task automatic test_init_passthrough();
      init_cke = 1'b0; init_cmd = CMD_PRE; init_ba = 3'd5; init_addr = 13'h0400;
      // requests and dones during INIT must be ignored
      {aref_req, wr_req, rd_req}    = 3'b111;
      {aref_done, wr_done, rd_done} = 3'b111;
      @(negedge clk);
      total_cnt++;
      if ({ddr2_cke, ddr2_cmd, ddr2_ba, ddr2_addr} !== {1'b0, CMD_PRE, 3'd5, 13'h0400})
         $display("FAIL init_pass: got cke=%b cmd=%b ba=%h addr=%h, want cke=0 cmd=0010 ba=5 addr=0400",
                  ddr2_cke, ddr2_cmd, ddr2_ba, ddr2_addr);
      else pass_cnt++;
      init_cke = 1'b1; init_cmd = CMD_LM;
      @(negedge clk);
      total_cnt++;
      if ({ddr2_cke, ddr2_cmd} !== {1'b1, CMD_LM})
         $display("FAIL init_cke_follow: got cke=%b cmd=%b, want cke=1 cmd=0000", ddr2_cke, ddr2_cmd);
      else pass_cnt++;
      total_cnt++;
      if ({aref_gnt, wr_gnt, rd_gnt} !== 3'b000 || dbg_state !== ST_INIT)
         $display("FAIL init_ignore_req: got gnt=%b%b%b state=%0d, want 000 state=%0d",
                  aref_gnt, wr_gnt, rd_gnt, dbg_state, ST_INIT);
      else pass_cnt++;
      {aref_req, wr_req, rd_req}    = 3'b000;
      {aref_done, wr_done, rd_done} = 3'b000;
   endtask

   task automatic test_init_end();
      init_end = 1'b1;
      @(negedge clk);
      total_cnt++;
      if (dbg_state !== ST_ARB || ddr2_cmd !== CMD_LM)
         $display("FAIL init_end_arb: got state=%0d cmd=%b, want state=%0d cmd=0000", dbg_state, ddr2_cmd, ST_ARB);
      else pass_cnt++;
      // dropping init_end later must not return to INIT
      init_end = 1'b0; init_cke = 1'b0; init_cmd = CMD_PRE;
      @(negedge clk);
      total_cnt++;
      if ({ddr2_cke, ddr2_cmd, ddr2_ba, ddr2_addr} !== {1'b1, CMD_NOP, 3'd5, 13'h0400} || dbg_state !== ST_ARB)
         $display("FAIL arb_idle: got cke=%b cmd=%b ba=%h addr=%h state=%0d, want cke=1 cmd=0111 ba=5 addr=0400 state=%0d",
                  ddr2_cke, ddr2_cmd, ddr2_ba, ddr2_addr, dbg_state, ST_ARB);
      else pass_cnt++;
   endtask

   task automatic test_round_robin();
      logic [1:0] id, exp;
      exp_q = '{2'd2, 2'd3, 2'd2};
      wr_req = 1'b1; rd_req = 1'b1;
      for (int g = 0; g < 3; g++) begin
         wait_grant(id);
         exp = exp_q.pop_front();
         total_cnt++;
         if (id !== exp) $display("FAIL rr_order[%0d]: got grant %0d want %0d", g, id, exp);
         else pass_cnt++;
         total_cnt++;
         if (ddr2_cmd !== CMD_NOP) $display("FAIL rr_gap_nop[%0d]: got cmd=%b want 0111", g, ddr2_cmd);
         else pass_cnt++;
         @(negedge clk);
         total_cnt++;
         if (ddr2_cmd !== ((exp == 2'd2) ? CMD_WR : CMD_RD))
            $display("FAIL rr_src_cmd[%0d]: got cmd=%b want %b", g, ddr2_cmd, (exp == 2'd2) ? CMD_WR : CMD_RD);
         else pass_cnt++;
         @(negedge clk);
         if (exp == 2'd2) wr_done = 1'b1; else rd_done = 1'b1;
         @(negedge clk);
         wr_done = 1'b0; rd_done = 1'b0;
         if (g == 2) begin wr_req = 1'b0; rd_req = 1'b0; end
         total_cnt++;
         if ({aref_gnt, wr_gnt, rd_gnt} !== 3'b000 || dbg_state !== ST_ARB)
            $display("FAIL rr_release[%0d]: got gnt=%b%b%b state=%0d, want 000 state=%0d",
                     g, aref_gnt, wr_gnt, rd_gnt, dbg_state, ST_ARB);
         else pass_cnt++;
      end
   endtask

   task automatic test_aref_no_preempt();
      logic [1:0] id;
      exp_q = '{2'd2, 2'd1, 2'd3};
      wr_req = 1'b1;
      wait_grant(id);
      total_cnt++;
      if (id !== exp_q.pop_front()) $display("FAIL ap_first: got grant %0d want 2", id);
      else pass_cnt++;
      // dropping the request while granted has no effect
      wr_req = 1'b0; aref_req = 1'b1; rd_req = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         total_cnt++;
         if ({aref_gnt, wr_gnt, rd_gnt} !== 3'b010)
            $display("FAIL ap_no_preempt[%0d]: got gnt=%b%b%b want 010", i, aref_gnt, wr_gnt, rd_gnt);
         else pass_cnt++;
      end
      wr_done = 1'b1;
      @(negedge clk);
      wr_done = 1'b0;
      wait_grant(id);
      total_cnt++;
      if (id !== exp_q.pop_front()) $display("FAIL ap_aref_next: got grant %0d want 1", id);
      else pass_cnt++;
      aref_req = 1'b0;
      @(negedge clk);
      total_cnt++;
      if (ddr2_cmd !== CMD_AREF) $display("FAIL ap_aref_cmd: got cmd=%b want 0001", ddr2_cmd);
      else pass_cnt++;
      aref_done = 1'b1;
      @(negedge clk);
      aref_done = 1'b0;
      wait_grant(id);
      total_cnt++;
      if (id !== exp_q.pop_front()) $display("FAIL ap_rd_last: got grant %0d want 3", id);
      else pass_cnt++;
      rd_req = 1'b0; rd_done = 1'b1;
      @(negedge clk);
      rd_done = 1'b0;
   endtask

   task automatic test_read_path();
      logic [1:0] id;
      rd_cmd = CMD_RD; rd_ba = 3'd2; rd_addr = 13'h0010;
      rd_req = 1'b1;
      wait_grant(id);
      total_cnt++;
      if (id !== 2'd3) $display("FAIL rd_grant: got grant %0d want 3", id);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if ({ddr2_cmd, ddr2_ba, ddr2_addr} !== {CMD_RD, 3'd2, 13'h0010})
         $display("FAIL rd_bus: got cmd=%b ba=%h addr=%h, want cmd=0101 ba=2 addr=0010", ddr2_cmd, ddr2_ba, ddr2_addr);
      else pass_cnt++;
      wr_done = 1'b1; aref_done = 1'b1;
      @(negedge clk);
      wr_done = 1'b0; aref_done = 1'b0;
      total_cnt++;
      if ({aref_gnt, wr_gnt, rd_gnt} !== 3'b001)
         $display("FAIL rd_ignore_done: got gnt=%b%b%b want 001", aref_gnt, wr_gnt, rd_gnt);
      else pass_cnt++;
      rd_req = 1'b0; rd_done = 1'b1;
      @(negedge clk);
      rd_done = 1'b0;
      total_cnt++;
      if ({aref_gnt, wr_gnt, rd_gnt} !== 3'b000)
         $display("FAIL rd_release: got gnt=%b%b%b want 000", aref_gnt, wr_gnt, rd_gnt);
      else pass_cnt++;
   endtask

   task automatic test_one_cycle_grant();
      logic [1:0] id;
      wr_req = 1'b1;
      wait_grant(id);
      total_cnt++;
      if (id !== 2'd2) $display("FAIL oc_grant: got grant %0d want 2", id);
      else pass_cnt++;
      wr_req = 1'b0; wr_done = 1'b1;
      @(negedge clk);
      wr_done = 1'b0;
      total_cnt++;
      if ({aref_gnt, wr_gnt, rd_gnt} !== 3'b000 || dbg_state !== ST_ARB)
         $display("FAIL oc_release: got gnt=%b%b%b state=%0d, want 000 state=%0d",
                  aref_gnt, wr_gnt, rd_gnt, dbg_state, ST_ARB);
      else pass_cnt++;
   endtask

   // Write granted and never released; a read waits behind it.
   task automatic test_hold_or_timeout();
      logic [1:0] id;
      int         n;
      wr_req = 1'b1;
      wait_grant(id);
      total_cnt++;
      if (id !== 2'd2) $display("FAIL hold_grant: got grant %0d want 2", id);
      else pass_cnt++;
      wr_req = 1'b0; rd_req = 1'b1;
`ifdef DDR2_ARB_TIMEOUT_EN
      n = 1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!wr_gnt) break;
         n++;
      end
      total_cnt++;
      if (n !== 8) $display("FAIL to_len: got %0d grant cycles want 8", n);
      else pass_cnt++;
      total_cnt++;
      if ({grant_timeout, ddr2_cmd} !== {1'b1, CMD_NOP})
         $display("FAIL to_pulse: got to=%b cmd=%b, want to=1 cmd=0111", grant_timeout, ddr2_cmd);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if ({grant_timeout, aref_gnt, wr_gnt, rd_gnt} !== 4'b0001)
         $display("FAIL to_next_rd: got to=%b gnt=%b%b%b, want to=0 gnt=001",
                  grant_timeout, aref_gnt, wr_gnt, rd_gnt);
      else pass_cnt++;
`else
      n = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (wr_gnt && !rd_gnt && !grant_timeout) n++;
      end
      total_cnt++;
      if (n !== 20) $display("FAIL hold_len: got %0d clean hold cycles want 20", n);
      else pass_cnt++;
      wr_done = 1'b1;
      @(negedge clk);
      wr_done = 1'b0;
      wait_grant(id);
      total_cnt++;
      if (id !== 2'd3 || grant_timeout !== 1'b0)
         $display("FAIL hold_next_rd: got grant %0d to=%b, want 3 to=0", id, grant_timeout);
      else pass_cnt++;
`endif
   endtask

   // Currently in READ: a mid-grant reset returns to INIT on the next edge.
   task automatic test_reset_mid_grant();
      rst_n = 1'b0;
      @(negedge clk);
      rd_req = 1'b0;
      total_cnt++;
      if (dbg_state !== ST_INIT || {aref_gnt, wr_gnt, rd_gnt} !== 3'b000 ||
          {ddr2_cke, ddr2_cmd} !== {1'b0, CMD_NOP})
         $display("FAIL mid_reset: got state=%0d gnt=%b%b%b cke=%b cmd=%b, want state=%0d gnt=000 cke=0 cmd=0111",
                  dbg_state, aref_gnt, wr_gnt, rd_gnt, ddr2_cke, ddr2_cmd, ST_INIT);
      else pass_cnt++;
      rst_n = 1'b1;
      @(negedge clk);
      total_cnt++;
      if (dbg_state !== ST_INIT)
         $display("FAIL post_reset_init: got state=%0d want %0d", dbg_state, ST_INIT);
      else pass_cnt++;
   endtask

   // ---------------- sequence + final report ----------------
   initial begin
      test_reset();
      test_init_passthrough();
      test_init_end();
      test_round_robin();
      test_aref_no_preempt();
      test_read_path();
      test_one_cycle_grant();
      test_hold_or_timeout();
      test_reset_mid_grant();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d done", pass_cnt, total_cnt);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/ddr2_cmd_arbiter.md
Name: ddr2_cmd_arbiter

Overview:
Owns the DDR2 command/address bus after power-up. Passes the init sequencer's cke/cmd/ba/addr through until init completes, then grants the bus to one of three requesters: auto-refresh, write and read. Refresh has fixed highest priority; write and read share the bus round-robin. Drives the registered command bus toward the PHY/pads.

Parameters:
BA_BITS, 3, bank address width
ADDR_BITS, 13, row/column address width
MAX_GRANT_CYCLES, 64, grant timeout in clk cycles; used only when DDR2_ARB_TIMEOUT_EN is defined

Ports:
clk  in  1  controller clock
rst_n  in  1  synchronous, active-low reset
init_end  in  1  init sequence complete; sticky once seen
init_cke  in  1  cke from init sequencer
init_cmd  in  4  {cs,ras,cas,we} from init sequencer
init_ba  in  BA_BITS  bank from init sequencer
init_addr  in  ADDR_BITS  address from init sequencer
aref_req / wr_req / rd_req  in  1 each  bus request, level
aref_done / wr_done / rd_done  in  1 each  one-cycle pulse from the granted source releasing the bus
aref_gnt / wr_gnt / rd_gnt  out  1 each  registered grant
aref_cmd / wr_cmd / rd_cmd  in  4 each  source command
aref_ba / wr_ba / rd_ba  in  BA_BITS each  source bank
aref_addr / wr_addr / rd_addr  in  ADDR_BITS each  source address
ddr2_cke  out  1  registered cke
ddr2_cmd  out  4  registered command
ddr2_ba  out  BA_BITS  registered bank
ddr2_addr  out  ADDR_BITS  registered address
grant_timeout  out  1  one-cycle error pulse; always 0 without DDR2_ARB_TIMEOUT_EN

Behaviour:
- Reset is synchronous and active-low (rst_n sampled on posedge clk), including mid-operation. Reset values:
  - state = INIT
  - all gnt = 0
  - ddr2_cke = 0, ddr2_cmd = NOP (4'b0111), ddr2_ba = 0, ddr2_addr = 0
  - grant_timeout = 0
  - last_served = READ
- States: INIT, ARB, AREF, WRITE, READ.
- INIT:
  - ddr2_* <= init_* each cycle (1-cycle latency).
  - init_end = 1 → ARB next cycle.
  - A later drop of init_end is ignored.
- ddr2_cke = 1 in every state other than INIT.
- ARB:
  - ddr2_cmd <= NOP; ba and addr hold their last value.
  - aref_req wins and moves to AREF.
  - Otherwise, if only one of wr_req/rd_req is set, that one wins.
  - If both are set, the one not equal to last_served wins.
  - No request: stay in ARB.
  - ARB lasts at least one cycle between consecutive grants.
- Grant states:
  - The matching gnt is 1 for every cycle in the state, starting the cycle the state is entered.
  - ddr2_cmd/ba/addr <= the granted source's cmd/ba/addr (1-cycle latency).
  - The matching *_done = 1 → ARB next cycle; gnt deasserts the same edge.
  - On leaving WRITE or READ, last_served is updated to that state.
- Boundary rules:
  - Dropping req while granted has no effect; the grant is held until done.
  - done from a non-granted source is ignored.
  - done in the entry cycle is honoured (1-cycle grant).
  - A new aref_req during WRITE/READ does not preempt; it is served at the next ARB.
  - Reqs/dones during INIT are ignored.

Optional Feature:
DDR2_ARB_TIMEOUT_EN:
- Defined: a counter runs in AREF/WRITE/READ and clears in ARB. If it reaches MAX_GRANT_CYCLES with no done:
  - the state is forced to ARB and the gnt is dropped;
  - grant_timeout pulses 1 cycle;
  - ddr2_cmd <= NOP;
  - last_served is updated as for a normal release.
- Undefined: no counter; grant_timeout is tied to 0; grants may be held indefinitely.

Decomposition:
- ddr2_pkg: command encodings, state enum.
  - NOP = 0111, PRE = 0010, AREF = 0001, LM = 0000, ACT = 0011, WR = 0100, RD = 0101.
  - States: INIT, ARB, AREF, WRITE, READ.
- Sub-module ddr2_arb_pick: combinational priority/round-robin chooser.
  - Inputs: aref_req, wr_req, rd_req, last_served.
  - Output: one-hot next grant.

Test Plan:
- Reset, then hold init_end = 0 with init_cmd = PRE, addr = 13'h0400 → ddr2_cmd = PRE and addr = 0400 one cycle later; all gnt = 0; ddr2_cke follows init_cke.
- init_end = 1, no reqs → ARB; ddr2_cmd = NOP, ddr2_cke = 1.
- wr_req and rd_req held together, each done 3 cycles after grant → grants alternate WRITE, READ, WRITE; at least one NOP cycle between grants.
- aref_req raised during a WRITE grant alongside rd_req → WRITE finishes, then AREF is granted before READ.
- rd_req granted, rd_cmd = RD, ba = 3'd2, addr = 13'h0010 → ddr2_cmd/ba/addr match one cycle later; wr_done pulse during the grant is ignored.
- DDR2_ARB_TIMEOUT_EN with MAX_GRANT_CYCLES = 8, wr grant never done → wr_gnt drops after 8 cycles, grant_timeout pulses 1 cycle, pending rd_req is granted next; separately, rst_n = 0 mid-grant → INIT and NOP on the next edge.
